// File: rtl/freq_pkg.sv
// Shared constants, FSM encoding and debug struct for the frequency report formatter.
// The byte tables feed the fixed " Hz\r\n" suffix and the optional "NO SIGNAL\r\n" line.
package freq_pkg;

  localparam int CNT_W_DEF      = 32;
  localparam int BCD_DIGITS_DEF = 10;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int SFX_LEN   = 5;
  localparam int NOSIG_LEN = 11;

  localparam logic [7:0] SFX_BYTES [SFX_LEN] = '{
    ASCII_SPACE, ASCII_H, ASCII_Z, ASCII_CR, ASCII_LF
  };

  localparam logic [7:0] NOSIG_BYTES [NOSIG_LEN] = '{
    8'h4E, 8'h4F, 8'h20, 8'h53, 8'h49, 8'h47, 8'h4E, 8'h41, 8'h4C, ASCII_CR, ASCII_LF
  };

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_LOCATE  = 3'd2,
    S_DIGITS  = 3'd3,
    S_SUFFIX  = 3'd4,
    S_NOSIG   = 3'd5
  } state_t;

  typedef struct packed {
    state_t state;
    logic   sig_flag;
  } dbg_t;

  function automatic logic [7:0] sfx_byte(input logic [3:0] pos);
    sfx_byte = ASCII_LF;
    for (int i = 0; i < SFX_LEN; i++) begin
      if (pos == 4'(i)) sfx_byte = SFX_BYTES[i];
    end
  endfunction

  function automatic logic [7:0] nosig_byte(input logic [3:0] pos);
    nosig_byte = ASCII_LF;
    for (int i = 0; i < NOSIG_LEN; i++) begin
      if (pos == 4'(i)) nosig_byte = NOSIG_BYTES[i];
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: a start pulse loads the binary value, CNT_W cycles later
// o_done rises and o_bcd holds the packed BCD result until the next start.
module bin2bcd_seq
  import freq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_bin,
  output logic [BCD_DIGITS*4-1:0] o_bcd,
  output logic                    o_done
);

  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int CW    = $clog2(CNT_W);

  logic [CNT_W-1:0] r_shift;
  logic [BCD_W-1:0] r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_done;
  logic [BCD_W-1:0] w_adj;

  // Add-3 on every nibble of 5 or more so the following shift carries into the next digit.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_bin;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_run) begin
      {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
      r_cnt            <= r_cnt + 1'b1;
      if (r_cnt == CW'(CNT_W - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/freq_report_fmt.sv
// Formats each frequency count as an ASCII line "<digits> Hz\r\n" for the UART.
// FREQ_REPORT_NOSIG_EN: a count taken without signal_detect prints "NO SIGNAL\r\n" instead.
module freq_report_fmt
  import freq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_valid,
  input  logic             signal_detect,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             dropped,
  output dbg_t             dbg
);

  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int IDX_W = $clog2(BCD_DIGITS);

  state_t             r_state;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_busy;
  logic               r_dropped;
  logic               r_sig;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_pos;

  logic               w_start;
  logic               w_done;
  logic               w_xfer;
  logic [BCD_W-1:0]   w_bcd;
  logic [IDX_W-1:0]   w_msd;
  logic [IDX_W-1:0]   w_idx_m1;
  logic [3:0]         w_nib_msd;
  logic [3:0]         w_nib_next;

  // Byte handshake: a byte moves on a clk edge where tx_valid && tx_ready; once tx_valid
  // rises, tx_data is frozen and tx_valid stays high until that transfer (no retraction).
  assign w_xfer = r_tx_valid && tx_ready;

`ifdef FREQ_REPORT_NOSIG_EN
  assign w_start = (r_state == S_IDLE) && count_valid && signal_detect;
`else
  assign w_start = (r_state == S_IDLE) && count_valid;
`endif

  bin2bcd_seq #(
    .CNT_W      (CNT_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (count_in),
    .o_bcd   (w_bcd),
    .o_done  (w_done)
  );

  // Highest nonzero nibble picks the first digit; an all-zero result falls back to index 0.
  always_comb begin
    w_msd      = '0;
    w_nib_msd  = '0;
    w_nib_next = '0;
    w_idx_m1   = r_idx - 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (w_bcd[i*4 +: 4] != 4'd0) begin
        w_msd     = IDX_W'(i);
        w_nib_msd = w_bcd[i*4 +: 4];
      end
      if (IDX_W'(i) == w_idx_m1) w_nib_next = w_bcd[i*4 +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
      r_sig      <= 1'b0;
      r_idx      <= '0;
      r_pos      <= '0;
    end else begin
      r_dropped <= count_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (count_valid) begin
            r_sig   <= signal_detect;
            r_busy  <= 1'b1;
            r_state <= S_CONVERT;
`ifdef FREQ_REPORT_NOSIG_EN
            if (!signal_detect) begin
              r_state    <= S_NOSIG;
              r_pos      <= '0;
              r_tx_data  <= nosig_byte(4'd0);
              r_tx_valid <= 1'b1;
            end
`endif
          end
        end
        S_CONVERT: begin
          if (w_done) r_state <= S_LOCATE;
        end
        S_LOCATE: begin
          r_idx      <= w_msd;
          r_tx_data  <= ASCII_ZERO + {4'h0, w_nib_msd};
          r_tx_valid <= 1'b1;
          r_state    <= S_DIGITS;
        end
        S_DIGITS: begin
          if (w_xfer) begin
            if (r_idx == '0) begin
              r_state   <= S_SUFFIX;
              r_pos     <= '0;
              r_tx_data <= sfx_byte(4'd0);
            end else begin
              r_idx     <= w_idx_m1;
              r_tx_data <= ASCII_ZERO + {4'h0, w_nib_next};
            end
          end
        end
        S_SUFFIX: begin
          if (w_xfer) begin
            if (r_pos == 4'(SFX_LEN - 1)) begin
              r_state    <= S_IDLE;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_busy     <= 1'b0;
            end else begin
              r_pos     <= r_pos + 4'd1;
              r_tx_data <= sfx_byte(r_pos + 4'd1);
            end
          end
        end
        S_NOSIG: begin
          if (w_xfer) begin
            if (r_pos == 4'(NOSIG_LEN - 1)) begin
              r_state    <= S_IDLE;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_busy     <= 1'b0;
            end else begin
              r_pos     <= r_pos + 4'd1;
              r_tx_data <= nosig_byte(r_pos + 4'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign dropped  = r_dropped;
  assign dbg      = '{state: r_state, sig_flag: r_sig};

endmodule

// File: tb/tb_freq_report_fmt.sv
// Directed bench for freq_report_fmt: expected lines are written out by hand and
// queued as bytes; inputs change 1ns after posedge, outputs are observed there.
module tb_freq_report_fmt;
  import freq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] count_in = '0;
  logic        count_valid = 1'b0;
  logic        signal_detect = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        dropped;
  dbg_t        dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  int          drop_cnt = 0;
  logic [7:0]  exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) if (dropped === 1'b1) drop_cnt++;

  freq_report_fmt dut (
    .clk           (clk),
    .rst           (rst),
    .count_in      (count_in),
    .count_valid   (count_valid),
    .signal_detect (signal_detect),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .dropped       (dropped),
    .dbg           (dbg)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse(input logic [31:0] v, input logic sig);
    count_in      = v;
    signal_detect = sig;
    count_valid   = 1'b1;
    step();
    count_valid   = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    while (tx_valid !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
    if (tx_valid !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: tx_valid never rose within %0d cycles", name, cycles);
    end
  endtask

  // scoreboard: pops exp_q on every transfer, checks hold-while-stalled and end of line
  task automatic drain(input int mode, input int budget, input string name);
    int         cyc = 0;
    int         low_left = 0;
    bit         stretched = 0;
    bit         pending = 0;
    bit         last = 0;
    bit         done = 0;
    logic [7:0] held = '0;
    logic [7:0] exp_b;
    while (!done && cyc < budget) begin
      if (pending) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin
          n_err++;
          $display("FAIL %s hold: valid=%b data=%h required valid=1 data=%h", name, tx_valid, tx_data, held);
        end
      end
      if (mode == 0) begin
        tx_ready = 1'b1;
      end else begin
        if (tx_valid === 1'b1 && !stretched) begin
          stretched = 1;
          low_left  = 20;
        end
        if (low_left > 0) begin
          tx_ready = 1'b0;
          low_left--;
        end else begin
          int r;
          r = $urandom_range(0, 9);
          if (r == 0) begin
            low_left = 19;
            tx_ready = 1'b0;
          end else begin
            tx_ready = (r > 4);
          end
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s extra byte: got %h required none", name, tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            n_err++;
            $display("FAIL %s byte: got %h required %h", name, tx_data, exp_b);
          end
          if (exp_q.size() == 0) last = 1;
        end
      end
      pending = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      held    = tx_data;
      step();
      cyc++;
      if (last) begin
        n_cmp++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s end: busy=%b valid=%b required 0 0", name, busy, tx_valid);
        end
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: %0d bytes outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset tx_data: got %h required 00", tx_data); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset tx_valid: got %b required 0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b required 0", busy); end
    n_cmp++; if (dropped !== 1'b0) begin n_err++; $display("FAIL reset dropped: got %b required 0", dropped); end
    n_cmp++; if (dbg.state !== S_IDLE) begin n_err++; $display("FAIL reset state: got %0d required 0", dbg.state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_1000();
    int n;
    tx_ready = 1'b1;
    push_line("1000 Hz");
    pulse(32'd1000, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic busy: got %b required 1", busy); end
    wait_valid("basic", n);
    n_cmp++; if (n != 34) begin n_err++; $display("FAIL basic latency: got %0d required 34", n); end
    drain(0, 200, "basic");
  endtask

  task automatic test_zero();
`ifdef FREQ_REPORT_NOSIG_EN
    push_line("NO SIGNAL");
`else
    push_line("0 Hz");
`endif
    pulse(32'd0, 1'b0);
    drain(0, 200, "zero");
  endtask

  task automatic test_max();
    push_line("4294967295 Hz");
    pulse(32'hFFFF_FFFF, 1'b1);
    drain(0, 300, "max");
  endtask

  task automatic test_backpressure();
    push_line("25000000 Hz");
    pulse(32'd25000000, 1'b1);
    drain(1, 3000, "backpressure");
  endtask

  task automatic test_overrun();
    int n;
    int d0;
    tx_ready = 1'b0;
    push_line("12 Hz");
    d0 = drop_cnt;
    pulse(32'd12, 1'b1);
    wait_valid("overrun", n);
    pulse(32'd7, 1'b1);
    step();
    step();
    n_cmp++; if (drop_cnt - d0 != 1) begin n_err++; $display("FAIL overrun dropped: got %0d pulses required 1", drop_cnt - d0); end
    n_cmp++; if (tx_data !== 8'h31 || tx_valid !== 1'b1) begin n_err++; $display("FAIL overrun hold: got %h/%b required 31/1", tx_data, tx_valid); end
    drain(0, 200, "overrun");
    repeat (5) step();
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL overrun idle: valid=%b busy=%b required 0 0", tx_valid, busy); end
    push_line("7 Hz");
    pulse(32'd7, 1'b1);
    drain(0, 200, "after_overrun");
  endtask

  task automatic test_reset_mid();
    int n;
    int cyc;
    tx_ready = 1'b1;
    pulse(32'd123, 1'b1);
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_convert: busy=%b valid=%b required 0 0", busy, tx_valid); end
    n_cmp++; if (dbg.state !== S_IDLE) begin n_err++; $display("FAIL rst_convert state: got %0d required 0", dbg.state); end
    #1 rst = 1'b0;
    step();
    pulse(32'd12345, 1'b1);
    wait_valid("rst_line", n);
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 100) begin
      if (tx_valid === 1'b1) n++;
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    n_cmp++; if (tx_data !== 8'h34 || tx_valid !== 1'b1) begin n_err++; $display("FAIL rst_line fourth: got %h/%b required 34/1", tx_data, tx_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL rst_line: valid=%b data=%h busy=%b required 0 00 0", tx_valid, tx_data, busy); end
    #1 rst = 1'b0;
    repeat (4) step();
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_resume: valid=%b required 0", tx_valid); end
    exp_q.delete();
    tx_ready = 1'b1;
    push_line("5 Hz");
    pulse(32'd5, 1'b1);
    drain(0, 200, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_1000();
    test_zero();
    test_max();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
